// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and an
// optional skid entry that breaks the combinational out_ready -> in_ready path.
module pipe_stage_reg #(
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned FLAG_W         = 1,
  parameter logic [31:0] RESET_PC       = 32'h0000_3000,
  parameter bit          BUBBLE_KEEP_PC = 1'b1,
  parameter bit          SKID           = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr_in,
  input  logic [31:0]       PC_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [FLAG_W-1:0] flag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr_out,
  output logic [31:0]       PC_out,
  output logic [DATA_W-1:0] data_out,
  output logic [FLAG_W-1:0] flag_out,
  output logic [1:0]        count
);

  logic              skid_valid;
  logic [31:0]       skid_instr;
  logic [31:0]       skid_pc;
  logic [DATA_W-1:0] skid_data;
  logic [FLAG_W-1:0] skid_flag;

  logic in_xfer;
  logic out_xfer;

  // Upstream ready: pass-through of out_ready without skid, skid occupancy with it.
  always_comb begin
    in_ready = 1'b0;
    if (SKID) begin
      in_ready = en & ~skid_valid;
    end else begin
      in_ready = en & (~out_valid | out_ready);
    end
  end

  // Handshake qualifiers; flush and reset suppress both directions.
  always_comb begin
    in_xfer  = in_valid & in_ready & en & ~flush & ~reset;
    out_xfer = out_valid & out_ready & en & ~flush & ~reset;
  end

  // Main entry: drives the out_* ports directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      instr_out <= '0;
      PC_out    <= RESET_PC;
      data_out  <= '0;
      flag_out  <= '0;
    end else if (flush) begin
      // Bubble is a nop; the PC optionally stays with the flushed entry.
      out_valid <= 1'b0;
      instr_out <= '0;
      data_out  <= '0;
      flag_out  <= '0;
      if (!BUBBLE_KEEP_PC || !out_valid) begin
        PC_out <= RESET_PC;
      end
    end else if (en) begin
      if (out_xfer && skid_valid) begin
        instr_out <= skid_instr;
        PC_out    <= skid_pc;
        data_out  <= skid_data;
        flag_out  <= skid_flag;
      end else if (in_xfer && (!out_valid || out_xfer)) begin
        out_valid <= 1'b1;
        instr_out <= instr_in;
        PC_out    <= PC_in;
        data_out  <= data_in;
        flag_out  <= flag_in;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Skid entry: catches an input while main is stalled, refills main on drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
      skid_data  <= '0;
      skid_flag  <= '0;
    end else if (flush) begin
      skid_valid <= 1'b0;
    end else if (en) begin
      if (out_xfer && skid_valid) begin
        skid_valid <= 1'b0;
      end else if (SKID && in_xfer && out_valid && !out_xfer) begin
        skid_valid <= 1'b1;
        skid_instr <= instr_in;
        skid_pc    <= PC_in;
        skid_data  <= data_in;
        skid_flag  <= flag_in;
      end
    end
  end

  // Occupancy counter tracking accepted minus delivered entries.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= 2'd0;
    end else if (en) begin
      count <= count + 2'(in_xfer) - 2'(out_xfer);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (scoreboarded, directed + random)
// and a single-entry instance (streaming and ready pass-through).
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [63:0] data;
    logic        flag;
  } item_t;

  logic clk;
  logic reset, en, flush;

  // Skid instance signals
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr_in, pc_in, instr_out, pc_out;
  logic [63:0] data_in, data_out;
  logic        flag_in, flag_out;
  logic [1:0]  count;

  // Single-entry instance signals
  logic        s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
  logic [31:0] s0_instr_in, s0_pc_in, s0_instr_out, s0_pc_out;
  logic [63:0] s0_data_in, s0_data_out;
  logic        s0_flag_in, s0_flag_out;
  logic [1:0]  s0_count;

  int total;
  int passed;

  item_t q1[$];
  item_t q0[$];

  pipe_stage_reg #(.SKID(1'b1)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .PC_in(pc_in), .data_in(data_in), .flag_in(flag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr_out(instr_out), .PC_out(pc_out), .data_out(data_out), .flag_out(flag_out),
    .count(count)
  );

  pipe_stage_reg #(.SKID(1'b0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready),
    .instr_in(s0_instr_in), .PC_in(s0_pc_in), .data_in(s0_data_in), .flag_in(s0_flag_in),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready),
    .instr_out(s0_instr_out), .PC_out(s0_pc_out), .data_out(s0_data_out), .flag_out(s0_flag_out),
    .count(s0_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    instr_in = instr;
    pc_in    = pc;
    data_in  = {instr, ~instr};
    flag_in  = instr[0];
  endtask

  // Scoreboard monitor for the skid instance (2-entry reference FIFO).
  always @(negedge clk) begin : mon1
    item_t e;
    item_t n;
    bit give;
    bit take;
    check("count1", 64'(count), 64'(q1.size()));
    check("out_valid1", 64'(out_valid), 64'(q1.size() != 0));
    check("in_ready1", 64'(in_ready), 64'(en && (q1.size() < 2)));
    if (reset || flush) begin
      q1.delete();
    end else begin
      give = en && out_ready && (q1.size() != 0);
      take = en && in_valid && (q1.size() < 2);
      if (give) begin
        e = q1.pop_front();
        check("instr1", 64'(instr_out), 64'(e.instr));
        check("pc1", 64'(pc_out), 64'(e.pc));
        check("data1", data_out, e.data);
        check("flag1", 64'(flag_out), 64'(e.flag));
      end
      if (take) begin
        n = '{instr: instr_in, pc: pc_in, data: data_in, flag: flag_in};
        q1.push_back(n);
      end
    end
  end

  // Scoreboard monitor for the single-entry instance.
  always @(negedge clk) begin : mon0
    item_t e;
    item_t n;
    bit give;
    bit take;
    check("count0", 64'(s0_count), 64'(q0.size()));
    check("out_valid0", 64'(s0_out_valid), 64'(q0.size() != 0));
    check("in_ready0", 64'(s0_in_ready), 64'(en && ((q0.size() == 0) || s0_out_ready)));
    if (reset || flush) begin
      q0.delete();
    end else begin
      give = en && s0_out_ready && (q0.size() != 0);
      take = en && s0_in_valid && ((q0.size() == 0) || s0_out_ready);
      if (give) begin
        e = q0.pop_front();
        check("instr0", 64'(s0_instr_out), 64'(e.instr));
        check("pc0", 64'(s0_pc_out), 64'(e.pc));
        check("data0", s0_data_out, e.data);
        check("flag0", 64'(s0_flag_out), 64'(e.flag));
      end
      if (take) begin
        n = '{instr: s0_instr_in, pc: s0_pc_in, data: s0_data_in, flag: s0_flag_in};
        q0.push_back(n);
      end
    end
  end

  initial begin
    total = 0;
    passed = 0;
    reset = 1'b1; en = 1'b1; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    drive(32'h0, 32'h0);
    s0_in_valid = 1'b0; s0_out_ready = 1'b0;
    s0_instr_in = '0; s0_pc_in = '0; s0_data_in = '0; s0_flag_in = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_pc", 64'(pc_out), 64'h3000);
    check("rst_instr", 64'(instr_out), 64'd0);
    check("rst_data", data_out, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Skid fill: A into main, B into skid, then drain in order
    in_valid = 1'b1; drive(32'hA, 32'h3008);
    step();
    check("fill_cnt1", 64'(count), 64'd1);
    drive(32'hB, 32'h300C);
    step();
    in_valid = 1'b0;
    #1;
    check("fill_cnt2", 64'(count), 64'd2);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    check("fill_main_instr", 64'(instr_out), 64'hA);
    check("fill_main_pc", 64'(pc_out), 64'h3008);
    out_ready = 1'b1;
    step();
    check("drain_cnt1", 64'(count), 64'd1);
    check("drain_instr_b", 64'(instr_out), 64'hB);
    step();
    check("drain_cnt0", 64'(count), 64'd0);
    out_ready = 1'b0;

    // Enable freeze with handshakes offered, then resume
    in_valid = 1'b1; drive(32'hC, 32'h3010);
    step();
    en = 1'b0; out_ready = 1'b1; drive(32'hD, 32'h3014);
    for (int i = 0; i < 3; i++) begin
      step();
      check("freeze_cnt", 64'(count), 64'd1);
      check("freeze_instr", 64'(instr_out), 64'hC);
    end
    en = 1'b1;
    step();
    check("resume_cnt", 64'(count), 64'd1);
    check("resume_instr", 64'(instr_out), 64'hD);
    in_valid = 1'b0;
    step();
    check("resume_empty", 64'(count), 64'd0);
    out_ready = 1'b0;

    // Flush overriding en=0 with two entries held
    in_valid = 1'b1; drive(32'hA, 32'h3008);
    step();
    drive(32'hB, 32'h300C);
    step();
    in_valid = 1'b0;
    flush = 1'b1; en = 1'b0;
    step();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_cnt", 64'(count), 64'd0);
    check("flush_instr", 64'(instr_out), 64'd0);
    check("flush_data", data_out, 64'd0);
    check("flush_pc_kept", 64'(pc_out), 64'h3008);
    en = 1'b1;
    step();
    check("flush_empty_pc", 64'(pc_out), 64'h3000);
    flush = 1'b0;

    // Reset together with flush and an offered input
    in_valid = 1'b1; drive(32'hE, 32'h4000);
    step();
    reset = 1'b1; flush = 1'b1; out_ready = 1'b1; drive(32'hF, 32'h4004);
    step();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("rstfl_pc", 64'(pc_out), 64'h3000);
    check("rstfl_cnt", 64'(count), 64'd0);
    check("rstfl_out_valid", 64'(out_valid), 64'd0);
    check("rstfl_in_ready", 64'(in_ready), 64'd1);

    // Single-entry stream 1..4 with 1-cycle latency
    s0_out_ready = 1'b1;
    s0_in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      s0_instr_in = 32'(k);
      s0_pc_in    = 32'h3000 + 32'(4 * k);
      s0_data_in  = 64'(k) << 8;
      s0_flag_in  = 1'(k);
      step();
      check("stream_instr", 64'(s0_instr_out), 64'(k));
      check("stream_cnt", 64'(s0_count), 64'd1);
    end
    s0_in_valid = 1'b0;
    step();
    check("stream_end_cnt", 64'(s0_count), 64'd0);

    // Single-entry in_ready follows out_ready combinationally when full
    s0_in_valid = 1'b1; s0_instr_in = 32'h55; s0_out_ready = 1'b0;
    step();
    s0_in_valid = 1'b0;
    #1;
    check("s0_ready_blocked", 64'(s0_in_ready), 64'd0);
    s0_out_ready = 1'b1;
    #1;
    check("s0_ready_pass", 64'(s0_in_ready), 64'd1);
    step();

    // Randomised handshakes, enable and flush against the reference FIFO
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom % 3) != 0;
      out_ready = ($urandom % 2) != 0;
      en        = ($urandom % 8) != 0;
      flush     = ($urandom % 40) == 0;
      instr_in  = $urandom;
      pc_in     = $urandom;
      data_in   = {$urandom, $urandom};
      flag_in   = 1'($urandom);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; en = 1'b1; out_ready = 1'b1;
    repeat (4) step();
    check("final_cnt", 64'(count), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
